// File: rtl/fb_scanout_dma.sv
// fb_scanout_dma
//   Frame-buffer scan-out engine. Reads a linear frame buffer over an AXI4
//   read master in fixed-length INCR bursts and replays it as a pixel stream.
//   A credit counter limits outstanding reads so that every returning beat
//   is guaranteed a slot in the output FIFO, which lets rready stay high.
//   Buffer swaps are latched with a level handshake and take effect at the
//   next frame start.
//
// Ports
//   aclk, resetn          clock, asynchronous active-low reset
//   swap, fbAddr          swap request level and requested buffer address
//   swapped               high when no swap is pending
//   m_mem_axi_ar*         AXI read address channel (master)
//   m_mem_axi_r*          AXI read data channel (rready always 1 after reset)
//   m_axis_t*             pixel stream, tuser = first beat, tlast = last beat
//   rdErr                 sticky flag, set by any non-OKAY rresp
module fb_scanout_dma #(
  parameter logic [31:0] FB_ADDR_DEFAULT = 32'h01E00000,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned FRAME_BEATS     = 307200,
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter logic [3:0]  AXI_ID          = 4'd0
) (
  input  logic                  aclk,
  input  logic                  resetn,

  input  logic                  swap,
  input  logic [31:0]           fbAddr,
  output logic                  swapped,

  output logic [3:0]            m_mem_axi_arid,
  output logic [31:0]           m_mem_axi_araddr,
  output logic [7:0]            m_mem_axi_arlen,
  output logic [2:0]            m_mem_axi_arsize,
  output logic [1:0]            m_mem_axi_arburst,
  output logic                  m_mem_axi_arvalid,
  input  logic                  m_mem_axi_arready,

  input  logic [DATA_WIDTH-1:0] m_mem_axi_rdata,
  input  logic [1:0]            m_mem_axi_rresp,
  input  logic                  m_mem_axi_rlast,
  input  logic                  m_mem_axi_rvalid,
  output logic                  m_mem_axi_rready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,

  output logic                  rdErr
);

  localparam int unsigned BYTES        = DATA_WIDTH / 8;
  localparam logic [31:0] BURST_BYTES  = 32'(BURST_LEN * BYTES);
  localparam int unsigned FRAME_BURSTS = FRAME_BEATS / BURST_LEN;
  localparam int unsigned BIW          = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int unsigned BCW          = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned CW           = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    NEXT
  } state_t;

  state_t                  state_q, state_d;
  logic                    issue;
  logic                    ar_hs;
  logic                    wr;
  logic                    pop;

  logic [CW-1:0]           credit_q;
  logic [BIW-1:0]          burst_idx_q;
  logic                    last_burst;
  logic [31:0]             cur_base_q;
  logic [31:0]             pend_addr_q;
  logic                    pending_q;
  logic                    swapped_q;
  logic                    use_pend;
  logic [31:0]             base_sel;
  logic [31:0]             araddr_q;
  logic                    rready_q;
  logic                    rd_err_q;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [BCW-1:0]          beat_q;

  // rlast carries no information here: burst length is fixed and credit
  // accounting is per beat.
  logic                    unused_rlast;
  assign unused_rlast = m_mem_axi_rlast;

  // ---------------------------------------------------------------------
  // Read address FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (credit_q >= CW'(BURST_LEN)) begin
          issue   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_mem_axi_arready) state_d = NEXT;
      end
      NEXT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_mem_axi_arvalid = (state_q == ADDR);
  assign m_mem_axi_araddr  = araddr_q;
  assign m_mem_axi_arid    = AXI_ID;
  assign m_mem_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_mem_axi_arsize  = 3'($clog2(BYTES));
  assign m_mem_axi_arburst = 2'b01;

  assign ar_hs      = m_mem_axi_arvalid && m_mem_axi_arready;
  assign last_burst = (burst_idx_q == BIW'(FRAME_BURSTS - 1));

  // A pending swap is taken at the issue of burst 0 so the whole frame,
  // including its first AR, comes from the new buffer.
  assign use_pend = issue && (burst_idx_q == '0) && pending_q;
  assign base_sel = use_pend ? pend_addr_q : cur_base_q;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      araddr_q    <= '0;
      burst_idx_q <= '0;
      cur_base_q  <= FB_ADDR_DEFAULT;
    end else begin
      if (issue) begin
        araddr_q <= base_sel + 32'(burst_idx_q) * BURST_BYTES;
        if (use_pend) cur_base_q <= pend_addr_q;
      end
      if (ar_hs) begin
        if (last_burst) burst_idx_q <= '0;
        else            burst_idx_q <= burst_idx_q + BIW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Swap handshake
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      swapped_q   <= 1'b1;
    end else begin
      // Acceptance needs pending low and the clear needs pending high, so
      // the two writes to pending_q never coincide; a swap accepted in the
      // frame-start cycle therefore waits for the following frame.
      if (use_pend) pending_q <= 1'b0;
      if (swap && swapped_q && !pending_q) begin
        pend_addr_q <= fbAddr;
        pending_q   <= 1'b1;
        swapped_q   <= 1'b0;
      end else if (!pending_q && !swap) begin
        swapped_q <= 1'b1;
      end
    end
  end

  assign swapped = swapped_q;

  // ---------------------------------------------------------------------
  // Credit: free FIFO slots not already promised to outstanding beats
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) credit_q <= CW'(FIFO_DEPTH);
    else         credit_q <= credit_q - (ar_hs ? CW'(BURST_LEN) : '0) + CW'(pop);
  end

  // ---------------------------------------------------------------------
  // Read data / FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      rready_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      if (wr && (m_mem_axi_rresp != 2'b00)) rd_err_q <= 1'b1;
    end
  end

  assign m_mem_axi_rready = rready_q;
  assign rdErr            = rd_err_q;

  assign wr  = m_mem_axi_rvalid && rready_q;
  assign pop = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (wr) mem[wr_ptr_q] <= m_mem_axi_rdata;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr) - CW'(pop);
    end
  end

  // Credit accounting guarantees room for every accepted beat.
  a_no_overflow: assert property (@(posedge aclk) disable iff (!resetn)
    !(wr && (count_q == CW'(FIFO_DEPTH)) && !pop));

  // ---------------------------------------------------------------------
  // Output stream and frame beat counter
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      beat_q <= '0;
    end else if (pop) begin
      if (beat_q == BCW'(FRAME_BEATS - 1)) beat_q <= '0;
      else                                 beat_q <= beat_q + BCW'(1);
    end
  end

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = mem[rd_ptr_q];
  assign m_axis_tuser  = m_axis_tvalid && (beat_q == '0);
  assign m_axis_tlast  = m_axis_tvalid && (beat_q == BCW'(FRAME_BEATS - 1));

endmodule

// File: tb/tb_fb_scanout_dma.sv
// tb_fb_scanout_dma
//   Directed bench for fb_scanout_dma (32-bit data, 4-beat bursts,
//   16-beat frames, 8-entry FIFO). A responder answers each AR with beats
//   whose data is the beat byte address; each driven beat is queued as the
//   expected stream word and checked when the DUT pops it.
module tb_fb_scanout_dma;

  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;
  localparam int unsigned FB = 16;
  localparam int unsigned FD = 8;
  localparam logic [31:0] DEF_ADDR = 32'h01E00000;

  logic          aclk = 1'b0;
  logic          resetn;
  logic          swap;
  logic [31:0]   fbAddr;
  logic          swapped;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tuser;
  logic          tlast;
  logic          tready;
  logic          rdErr;

  always #5 aclk = ~aclk;

  fb_scanout_dma #(
    .FB_ADDR_DEFAULT (DEF_ADDR),
    .DATA_WIDTH      (DW),
    .BURST_LEN       (BL),
    .FRAME_BEATS     (FB),
    .FIFO_DEPTH      (FD),
    .AXI_ID          (4'd0)
  ) dut (
    .aclk              (aclk),
    .resetn            (resetn),
    .swap              (swap),
    .fbAddr            (fbAddr),
    .swapped           (swapped),
    .m_mem_axi_arid    (arid),
    .m_mem_axi_araddr  (araddr),
    .m_mem_axi_arlen   (arlen),
    .m_mem_axi_arsize  (arsize),
    .m_mem_axi_arburst (arburst),
    .m_mem_axi_arvalid (arvalid),
    .m_mem_axi_arready (arready),
    .m_mem_axi_rdata   (rdata),
    .m_mem_axi_rresp   (rresp),
    .m_mem_axi_rlast   (rlast),
    .m_mem_axi_rvalid  (rvalid),
    .m_mem_axi_rready  (rready),
    .m_axis_tdata      (tdata),
    .m_axis_tvalid     (tvalid),
    .m_axis_tuser      (tuser),
    .m_axis_tlast      (tlast),
    .m_axis_tready     (tready),
    .rdErr             (rdErr)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard and responder state
  logic [31:0] exp_data[$];
  logic [31:0] burst_q[$];
  logic        arready_en;
  logic        inject_err;
  int          ar_count;
  int          pop_count;
  int          bench_beat;
  int          exp_idx;
  logic [31:0] exp_base;
  logic [31:0] last_ar_addr;
  logic        tb_pending;
  logic [31:0] tb_pend_addr;
  logic        r_active;
  logic [31:0] r_addr;
  int          r_beat;
  logic        stall_prev;
  logic [31:0] stall_data;
  logic        ar_stall_prev;
  logic [31:0] ar_hold_addr;

  // Monitor / responder: runs 2 time units after each falling edge, after
  // the main sequence has updated its inputs, and decides what happens at
  // the following rising edge.
  initial begin
    rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; arready = 1'b0;
    forever begin
      @(negedge aclk);
      #2;
      if (!resetn) begin
        exp_data.delete();
        burst_q.delete();
        ar_count = 0; pop_count = 0; bench_beat = 0; exp_idx = 0;
        exp_base = DEF_ADDR; tb_pending = 1'b0; r_active = 1'b0; r_beat = 0;
        stall_prev = 1'b0; ar_stall_prev = 1'b0;
        rvalid = 1'b0; rresp = '0; rlast = 1'b0; arready = 1'b0;
        continue;
      end

      // Stream side
      if (stall_prev) begin
        chk("tvalid_hold", 32'(tvalid), 32'd1);
        chk("tdata_hold", tdata, stall_data);
      end
      if (tvalid && tready) begin
        if (exp_data.size() == 0) begin
          chk("stream_unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("tdata", tdata, exp_data.pop_front());
        end
        chk("tuser", 32'(tuser), 32'(bench_beat == 0));
        chk("tlast", 32'(tlast), 32'(bench_beat == int'(FB) - 1));
        bench_beat = (bench_beat + 1) % int'(FB);
        pop_count++;
      end
      stall_prev = tvalid && !tready;
      stall_data = tdata;

      // R responder: serve bursts recorded on earlier edges only
      rvalid = 1'b0; rlast = 1'b0; rresp = '0;
      if (!r_active && burst_q.size() > 0) begin
        r_addr   = burst_q.pop_front();
        r_beat   = 0;
        r_active = 1'b1;
      end
      if (r_active && rready) begin
        rvalid = 1'b1;
        rdata  = r_addr + 32'(r_beat * 4);
        rlast  = (r_beat == int'(BL) - 1);
        if (inject_err) begin
          rresp      = 2'd2;
          inject_err = 1'b0;
        end
        exp_data.push_back(rdata);
        r_beat++;
        if (r_beat == int'(BL)) r_active = 1'b0;
      end

      // AR side
      if (ar_stall_prev) begin
        chk("arvalid_hold", 32'(arvalid), 32'd1);
        chk("araddr_hold", araddr, ar_hold_addr);
      end
      arready = arready_en;
      if (arvalid && arready) begin
        if (exp_idx == 0 && tb_pending) begin
          exp_base   = tb_pend_addr;
          tb_pending = 1'b0;
        end
        chk("araddr", araddr, exp_base + 32'(exp_idx * 16));
        chk("arlen", 32'(arlen), 32'd3);
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst_arid", 32'({arburst, arid}), 32'h10);
        last_ar_addr = araddr;
        burst_q.push_back(araddr);
        ar_count++;
        exp_idx = (exp_idx + 1) % int'(FB / BL);
        chk("outstanding_within_fifo", 32'((ar_count * int'(BL) - pop_count) <= int'(FD)), 32'd1);
      end
      ar_stall_prev = arvalid && !arready;
      ar_hold_addr  = araddr;
    end
  end

  // Main directed sequence: inputs change 1 time unit after falling edges.
  initial begin
    int          n0;
    logic [31:0] a0;
    resetn = 1'b0; swap = 1'b0; fbAddr = '0; tready = 1'b1;
    arready_en = 1'b1; inject_err = 1'b0; tb_pending = 1'b0; tb_pend_addr = '0;

    repeat (3) @(negedge aclk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tuser_tlast", 32'({tuser, tlast}), 32'd0);
    chk("rst_rdErr", 32'(rdErr), 32'd0);
    chk("rst_swapped", 32'(swapped), 32'd1);
    resetn = 1'b1;

    // Free-running: two full frames of ARs and stream beats
    for (int i = 0; i < 300 && pop_count < 34; i++) begin @(negedge aclk); #1; end
    chk("wait_two_frames", 32'(pop_count >= 34), 32'd1);

    // Swap mid-frame, right after burst 1 of a frame was accepted
    for (int i = 0; i < 100 && exp_idx != 2; i++) begin @(negedge aclk); #1; end
    chk("wait_mid_frame", 32'(exp_idx), 32'd2);
    swap = 1'b1; fbAddr = 32'h02000000;
    tb_pend_addr = 32'h02000000; tb_pending = 1'b1;
    @(negedge aclk); #1;
    chk("swapped_low_after_accept", 32'(swapped), 32'd0);
    fbAddr = 32'h03000000;
    for (int i = 0; i < 200 && tb_pending; i++) begin @(negedge aclk); #1; end
    chk("wait_swap_applied", 32'(tb_pending), 32'd0);
    repeat (3) @(negedge aclk);
    #1;
    chk("swapped_low_while_swap_held", 32'(swapped), 32'd0);
    swap = 1'b0;
    @(negedge aclk); #1;
    chk("swapped_high_after_release", 32'(swapped), 32'd1);
    n0 = ar_count;
    for (int i = 0; i < 200 && ar_count < n0 + 5; i++) begin @(negedge aclk); #1; end
    chk("wait_frame_after_swap", 32'(ar_count >= n0 + 5), 32'd1);

    // Stream back-pressure: reads must stop once the FIFO is committed
    tready = 1'b0;
    repeat (30) @(negedge aclk);
    #1;
    n0 = ar_count;
    repeat (10) @(negedge aclk);
    #1;
    chk("no_ar_while_full", 32'(ar_count), 32'(n0));
    chk("tvalid_while_stalled", 32'(tvalid), 32'd1);
    tready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge aclk); #1;
      tready = 1'($urandom_range(0, 1));
    end
    tready = 1'b1;

    // AR back-pressure for 5 cycles
    arready_en = 1'b0;
    for (int i = 0; i < 50 && !arvalid; i++) begin @(negedge aclk); #1; end
    chk("wait_arvalid", 32'(arvalid), 32'd1);
    a0 = araddr;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk); #1;
      chk("arvalid_stable", 32'(arvalid), 32'd1);
      chk("araddr_stable", araddr, a0);
    end
    arready_en = 1'b1;

    // Error response on one beat
    inject_err = 1'b1;
    for (int i = 0; i < 100 && inject_err; i++) begin @(negedge aclk); #1; end
    chk("wait_err_beat", 32'(inject_err), 32'd0);
    repeat (3) @(negedge aclk);
    #1;
    chk("rdErr_set", 32'(rdErr), 32'd1);
    repeat (40) @(negedge aclk);
    #1;
    chk("rdErr_sticky", 32'(rdErr), 32'd1);

    // Reset while the second burst of a frame is in flight
    for (int i = 0; i < 100 && exp_idx != 2; i++) begin @(negedge aclk); #1; end
    chk("wait_second_burst", 32'(exp_idx), 32'd2);
    @(negedge aclk); #1;
    resetn = 1'b0;
    #2;
    chk("midrst_arvalid", 32'(arvalid), 32'd0);
    chk("midrst_rready", 32'(rready), 32'd0);
    chk("midrst_tvalid", 32'(tvalid), 32'd0);
    chk("midrst_tuser_tlast", 32'({tuser, tlast}), 32'd0);
    chk("midrst_rdErr", 32'(rdErr), 32'd0);
    chk("midrst_swapped", 32'(swapped), 32'd1);
    @(negedge aclk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 50 && ar_count < 1; i++) begin @(negedge aclk); #1; end
    chk("wait_restart_ar", 32'(ar_count >= 1), 32'd1);
    chk("restart_araddr", last_ar_addr, DEF_ADDR);
    for (int i = 0; i < 200 && pop_count < 20; i++) begin @(negedge aclk); #1; end
    chk("wait_restart_frame", 32'(pop_count >= 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
